// File: rtl/layer1_relu_maxpool.sv
// layer1_relu_maxpool
//   Applies ReLU followed by 2x2 / stride-2 max pooling to the layer-1
//   convolution stream. Input and output are both raster-ordered streams.
//   A single line buffer of COL/2 entries holds the horizontal pair maxima
//   of each even row until the matching odd row arrives.
//
// Handshake (both sides): a beat transfers on a rising edge where
//   valid & ready. A producer holds valid and data stable until the transfer.
//   in_ready = ~(out_valid & ~out_ready), so a full-rate stream with
//   out_ready held high never stalls.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    signed conv sum (DW bits)
//   in_valid   in_data valid
//   in_ready   block can accept in_data this cycle
//   out_data   pooled value (never negative)
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   frame_done one-cycle pulse after the last pooled value of a frame transfers
module layer1_relu_maxpool #(
    parameter int COL = 30,
    parameter int ROW = 30,
    parameter int DW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          frame_done
);

    localparam int CW   = (COL > 1) ? $clog2(COL) : 1;
    localparam int RW   = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int HALF = COL / 2;
    localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [DW-1:0] pair_reg;
    logic          last;
    logic [DW-1:0] linebuf [HALF];

    logic          accept;
    logic          xfer;
    logic [DW-1:0] relu;
    logic [IW-1:0] idx;
    logic [DW-1:0] lb_rd;
    logic          col_last;
    logic          row_last;

    // Both operands are already non-negative, so an unsigned compare is exact.
    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    assign in_ready = ~(out_valid & ~out_ready);
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;
    assign relu     = in_data[DW-1] ? '0 : in_data;
    assign idx      = IW'(col_cnt >> 1);
    assign lb_rd    = linebuf[idx];
    assign col_last = (col_cnt == CW'(COL - 1));
    assign row_last = (row_cnt == RW'(ROW - 1));

    // Position counters: col wraps each row, row wraps each frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    // Horizontal pair register: even rows hold the left pixel, odd rows hold
    // the max of the left pixel and the stored upper pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_reg <= '0;
        end else if (accept && !col_cnt[0]) begin
            pair_reg <= row_cnt[0] ? max2(relu, lb_rd) : relu;
        end
    end

    // Line buffer has no reset: every entry is written on an even row before
    // the odd row reads it.
    always_ff @(posedge clk) begin
        if (accept && !row_cnt[0] && col_cnt[0]) begin
            linebuf[idx] <= max2(pair_reg, relu);
        end
    end

    // Output register. A new pooled value loaded in the same cycle as a
    // transfer wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            last       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= xfer & last;
            if (accept && row_cnt[0] && col_cnt[0]) begin
                out_data  <= max2(pair_reg, relu);
                out_valid <= 1'b1;
                last      <= row_last & col_last;
            end else if (xfer) begin
                out_valid <= 1'b0;
                last      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_layer1_relu_maxpool.sv
module tb_layer1_relu_maxpool;

    logic        clk;
    logic        rst;

    // Small 4x4 instance
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        frame_done;

    // Default-size instance
    logic [15:0] b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [15:0] b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_frame_done;

    int errors;
    int checks;
    int cyc;

    logic [15:0] got_q[$];
    int          fd_count;
    int          fd_cyc;
    int          last_xfer_cyc;
    int          sign_cnt;

    int b_cnt, b_nz, b_sign, b_fd, b_acc;

    logic [15:0] frame_v [16];

    layer1_relu_maxpool #(.COL(4), .ROW(4), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_done(frame_done)
    );

    layer1_relu_maxpool dut_b (
        .clk(clk), .rst(rst),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .frame_done(b_frame_done)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // ---------------- output monitors ----------------
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            last_xfer_cyc = cyc;
            if (out_data[15]) sign_cnt++;
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
        end
        if (b_out_valid && b_out_ready) begin
            b_cnt++;
            if (b_out_data != 16'd0) b_nz++;
            if (b_out_data[15]) b_sign++;
        end
        if (b_frame_done) b_fd++;
        if (b_in_valid && b_in_ready) b_acc++;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_obs();
        got_q.delete();
        fd_count = 0;
        fd_cyc = -1;
        last_xfer_cyc = -1;
        sign_cnt = 0;
    endtask

    task automatic send_beat(input logic [15:0] v);
        int n;
        in_data  = v;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] add);
        for (int i = 0; i < 16; i++) send_beat(frame_v[i] + add);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_basic();
        frame_v = '{16'd1, -16'sd5, 16'd3, 16'd2,
                    16'd4, 16'd0, -16'sd7, 16'd9,
                    -16'sd1, -16'sd1, 16'd6, 16'd6,
                    16'd8, 16'd2, 16'd5, -16'sd3};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        b_in_valid = 1'b0;
        b_in_data = '0;
        b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [15:0] exp [4];
        logic [15:0] g;
        exp = '{16'd4, 16'd9, 16'd8, 16'd6};
        load_basic();
        clear_obs();
        send_frame(16'd0);
        idle(5);
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL basic_count got=%0d want=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            checks++;
            if (g !== exp[i]) begin errors++; $display("FAIL basic_out%0d got=%0d want=%0d", i, g, exp[i]); end
        end
        checks++;
        if (fd_count != 1) begin errors++; $display("FAIL basic_fd_count got=%0d want=1", fd_count); end
        checks++;
        if (fd_cyc != last_xfer_cyc + 1) begin
            errors++; $display("FAIL basic_fd_timing got=%0d want=%0d", fd_cyc, last_xfer_cyc + 1);
        end
        checks++;
        if (sign_cnt != 0) begin errors++; $display("FAIL basic_sign got=%0d want=0", sign_cnt); end
    endtask

    task automatic test_extremes();
        logic [15:0] exp [4];
        logic [15:0] g;
        exp = '{16'd32767, 16'd0, 16'd0, 16'd0};
        frame_v = '{16'h7FFF, 16'h8000, 16'h8000, 16'h8000,
                    16'h0000, 16'h0001, 16'h8000, 16'h8000,
                    16'h0000, 16'h0000, 16'h0000, 16'h0000,
                    16'h0000, 16'h0000, 16'h0000, 16'h0000};
        clear_obs();
        send_frame(16'd0);
        idle(5);
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            checks++;
            if (g !== exp[i]) begin errors++; $display("FAIL extreme_out%0d got=%0d want=%0d", i, g, exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp [4];
        logic [15:0] g;
        exp = '{16'd4, 16'd9, 16'd8, 16'd6};
        load_basic();
        clear_obs();
        fork
            begin
                send_frame(16'd0);
                idle(12);
            end
            begin
                int n;
                n = 0;
                @(posedge clk);
                #1;
                while (!out_valid && n < 40) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                checks++;
                if (!out_valid) begin errors++; $display("FAIL bp_no_output out_valid=%b want=1", out_valid); end
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got=%b want=0", k, in_ready); end
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== 16'd4) begin
                        errors++; $display("FAIL bp_hold%0d got=%b/%0d want=1/4", k, out_valid, out_data);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL bp_count got=%0d want=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            checks++;
            if (g !== exp[i]) begin errors++; $display("FAIL bp_out%0d got=%0d want=%0d", i, g, exp[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] exp [4];
        logic [15:0] g;
        exp = '{16'd4, 16'd9, 16'd8, 16'd6};
        load_basic();
        clear_obs();
        for (int i = 0; i < 6; i++) send_beat(frame_v[i]);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_obs();
        send_frame(16'd0);
        idle(5);
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL midrst_count got=%0d want=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            checks++;
            if (g !== exp[i]) begin errors++; $display("FAIL midrst_out%0d got=%0d want=%0d", i, g, exp[i]); end
        end
        checks++;
        if (fd_count != 1) begin errors++; $display("FAIL midrst_fd got=%0d want=1", fd_count); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [8];
        logic [15:0] g;
        exp = '{16'd4, 16'd9, 16'd8, 16'd6, 16'd5, 16'd10, 16'd9, 16'd7};
        load_basic();
        clear_obs();
        send_frame(16'd0);
        send_frame(16'd1);
        idle(5);
        checks++;
        if (got_q.size() != 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", got_q.size()); end
        for (int i = 0; i < 8; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            checks++;
            if (g !== exp[i]) begin errors++; $display("FAIL b2b_out%0d got=%0d want=%0d", i, g, exp[i]); end
        end
        checks++;
        if (fd_count != 2) begin errors++; $display("FAIL b2b_fd got=%0d want=2", fd_count); end
    endtask

    task automatic test_all_negative();
        int n;
        b_cnt = 0; b_nz = 0; b_sign = 0; b_fd = 0; b_acc = 0;
        b_in_data = 16'hFF9C; // -100
        b_in_valid = 1'b1;
        n = 0;
        while (b_acc < 900 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        b_in_valid = 1'b0;
        checks++;
        if (b_acc != 900) begin errors++; $display("FAIL neg_accepts got=%0d want=900", b_acc); end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (b_cnt != 225) begin errors++; $display("FAIL neg_count got=%0d want=225", b_cnt); end
        checks++;
        if (b_nz != 0) begin errors++; $display("FAIL neg_nonzero got=%0d want=0", b_nz); end
        checks++;
        if (b_sign != 0) begin errors++; $display("FAIL neg_sign got=%0d want=0", b_sign); end
        checks++;
        if (b_fd != 1) begin errors++; $display("FAIL neg_fd got=%0d want=1", b_fd); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        clear_obs();
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        test_all_negative();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
